// File: rtl/mem_bus_pkg.sv
// Shared definitions for the data-memory bus return path.
package mem_bus_pkg;

  // Target indices on the data-memory bus.
  localparam int unsigned TGT_RAM = 0;
  localparam int unsigned TGT_ROM = 1;
  localparam int unsigned TGT_CAM = 2;
  localparam int unsigned TGT_IO  = 3;

  // One-hot selects as produced by the address decoder.
  localparam logic [3:0] SEL_RAM = 4'b0001;
  localparam logic [3:0] SEL_ROM = 4'b0010;
  localparam logic [3:0] SEL_CAM = 4'b0100;
  localparam logic [3:0] SEL_IO  = 4'b1000;

  // Response FSM states.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_rsp_state_t;

  // Data returned for stores and for errored accesses.
  localparam logic [31:0] DATA_ZERO = 32'h0000_0000;

endpackage

// File: rtl/onehot_mux.sv
// One-hot data selector: ORs together the slices whose select bit is set and
// reports whether the select vector is exactly one-hot.
module onehot_mux #(
  parameter int unsigned N_TGT  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic [N_TGT-1:0]        sel_i,
  input  logic [N_TGT*DATA_W-1:0] data_i,
  output logic [DATA_W-1:0]       data_o,
  output logic                    is_onehot_o
);

  // AND-OR select; a zero select yields zero data.
  always_comb begin
    data_o = '0;
    for (int i = 0; i < int'(N_TGT); i++) begin
      if (sel_i[i]) begin
        data_o = data_o | data_i[i*DATA_W +: DATA_W];
      end
    end
    is_onehot_o = (sel_i != '0) && ((sel_i & (sel_i - N_TGT'(1))) == '0);
  end

endmodule

// File: rtl/mem_response_mux.sv
// Data-memory bus return path: latches the target select of an issued
// request, waits for that target's ready, routes its read data back to the
// MEM stage and stalls the pipeline until the response. Illegal selects and
// unanswered requests come back as a bus error.
module mem_response_mux
  import mem_bus_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned N_TGT   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_we,
  input  logic [N_TGT-1:0]        mem_select,
  input  logic [N_TGT*DATA_W-1:0] tgt_rdata,
  input  logic [N_TGT-1:0]        tgt_ready,
  output logic [DATA_W-1:0]       rdata,
  output logic                    rsp_valid,
  output logic                    stall,
  output logic                    bus_error
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  mem_rsp_state_t    state_q, state_d;
  logic [N_TGT-1:0]  sel_q, sel_d;
  logic              we_q, we_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [N_TGT-1:0]  mux_sel;
  logic [DATA_W-1:0] mux_data;
  logic              mux_onehot;

  // A single mux serves both jobs: in IDLE it checks the incoming select for
  // legality, afterwards it steers the latched target's data.
  assign mux_sel = (state_q == IDLE) ? mem_select : sel_q;

  onehot_mux #(
    .N_TGT (N_TGT),
    .DATA_W(DATA_W)
  ) u_onehot_mux (
    .sel_i      (mux_sel),
    .data_i     (tgt_rdata),
    .data_o     (mux_data),
    .is_onehot_o(mux_onehot)
  );

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    stall     = 1'b0;
    rsp_valid = 1'b0;
    bus_error = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Freeze in the same cycle the request is issued.
        stall = req_valid;
        if (req_valid) begin
          if (mux_onehot) begin
            sel_d   = mem_select;
            we_d    = req_we;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = WAIT;
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        // Ready from the selected target wins over a coincident timeout.
        if ((tgt_ready & sel_q) != '0) begin
          rdata_d = we_q ? '0 : mux_data;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CntMax) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RESP: begin
        // req_valid here is the instruction being answered; never re-accept.
        rsp_valid = 1'b1;
        bus_error = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdata = rdata_q;

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_response_mux.sv
// Directed bench for mem_response_mux.
module tb_mem_response_mux;
  import mem_bus_pkg::*;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned N_TGT   = 4;
  localparam int unsigned TIMEOUT = 16;

  logic                    clk;
  logic                    reset;
  logic                    req_valid;
  logic                    req_we;
  logic [N_TGT-1:0]        mem_select;
  logic [N_TGT*DATA_W-1:0] tgt_rdata;
  logic [N_TGT-1:0]        tgt_ready;
  logic [DATA_W-1:0]       rdata;
  logic                    rsp_valid;
  logic                    stall;
  logic                    bus_error;

  int n_tests;
  int n_fail;

  mem_response_mux #(
    .DATA_W (DATA_W),
    .N_TGT  (N_TGT),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .mem_select(mem_select),
    .tgt_rdata (tgt_rdata),
    .tgt_ready (tgt_ready),
    .rdata     (rdata),
    .rsp_valid (rsp_valid),
    .stall     (stall),
    .bus_error (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    mem_select = '0;
    tgt_rdata  = '0;
    tgt_ready  = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_tests++;
    if (rdata !== 32'h0) begin
      $display("FAIL reset_rdata: got %h want %h", rdata, 32'h0); n_fail++;
    end
    n_tests++;
    if ({rsp_valid, bus_error, stall} !== 3'b000) begin
      $display("FAIL reset_flags: got %b want 000", {rsp_valid, bus_error, stall}); n_fail++;
    end
  endtask

  task automatic test_ram_load();
    req_valid  = 1'b1;
    req_we     = 1'b0;
    mem_select = SEL_RAM;
    tgt_rdata[TGT_RAM*DATA_W +: DATA_W] = 32'h1234_5678;
    #1;
    n_tests++;
    if ({stall, rsp_valid} !== 2'b10) begin
      $display("FAIL ram_issue_stall: got %b want 10", {stall, rsp_valid}); n_fail++;
    end
    tick();
    tgt_ready = SEL_RAM;
    #1;
    n_tests++;
    if ({stall, rsp_valid} !== 2'b10) begin
      $display("FAIL ram_wait_stall: got %b want 10", {stall, rsp_valid}); n_fail++;
    end
    tick();
    tgt_ready = '0;
    #1;
    n_tests++;
    if ({rsp_valid, bus_error, stall} !== 3'b100 || rdata !== 32'h1234_5678) begin
      $display("FAIL ram_resp: got v/e/s=%b rdata=%h want 100 12345678",
               {rsp_valid, bus_error, stall}, rdata); n_fail++;
    end
    req_valid = 1'b0;
    tick();
    n_tests++;
    if (rsp_valid !== 1'b0 || rdata !== 32'h1234_5678) begin
      $display("FAIL ram_hold: got v=%b rdata=%h want 0 12345678", rsp_valid, rdata); n_fail++;
    end
  endtask

  task automatic test_store();
    req_valid  = 1'b1;
    req_we     = 1'b1;
    mem_select = SEL_RAM;
    tgt_rdata[TGT_RAM*DATA_W +: DATA_W] = 32'hAAAA_5555;
    tgt_ready  = SEL_RAM;
    tick();
    tick();
    // req_valid stays high through RESP: same instruction.
    n_tests++;
    if ({rsp_valid, bus_error, stall} !== 3'b100 || rdata !== 32'h0) begin
      $display("FAIL store_resp: got v/e/s=%b rdata=%h want 100 00000000",
               {rsp_valid, bus_error, stall}, rdata); n_fail++;
    end
    tick();
    n_tests++;
    if ({rsp_valid, stall} !== 2'b01) begin
      $display("FAIL store_no_reaccept: got v/s=%b want 01", {rsp_valid, stall}); n_fail++;
    end
    // Next instruction: a load issued from this IDLE cycle.
    req_we = 1'b0;
    tgt_rdata[TGT_RAM*DATA_W +: DATA_W] = 32'h0BAD_F00D;
    tick();
    n_tests++;
    if ({rsp_valid, stall} !== 2'b01) begin
      $display("FAIL next_wait: got v/s=%b want 01", {rsp_valid, stall}); n_fail++;
    end
    tick();
    n_tests++;
    if (rsp_valid !== 1'b1 || rdata !== 32'h0BAD_F00D) begin
      $display("FAIL next_resp: got v=%b rdata=%h want 1 0badf00d", rsp_valid, rdata); n_fail++;
    end
    req_valid = 1'b0;
    tgt_ready = '0;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    req_valid  = 1'b1;
    mem_select = SEL_RAM;
    tgt_ready  = '0;
    tick();
    tick();
    // Second WAIT cycle: abandon the transaction.
    reset     = 1'b1;
    req_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    n_tests++;
    if ({rsp_valid, bus_error, stall} !== 3'b000 || rdata !== 32'h0) begin
      $display("FAIL rst_wait_outputs: got v/e/s=%b rdata=%h want 000 00000000",
               {rsp_valid, bus_error, stall}, rdata); n_fail++;
    end
    tgt_ready = SEL_RAM;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (rsp_valid !== 1'b0) begin
        $display("FAIL rst_wait_no_resp: got v=%b want 0 (cycle %0d)", rsp_valid, i); n_fail++;
      end
    end
    tgt_ready = '0;
  endtask

  task automatic test_cam_latency();
    req_valid  = 1'b1;
    mem_select = SEL_CAM;
    tgt_rdata[TGT_RAM*DATA_W +: DATA_W] = 32'h1111_1111;
    tgt_rdata[TGT_CAM*DATA_W +: DATA_W] = 32'hCAFE_F00D;
    tick();
    for (int w = 1; w <= 5; w++) begin
      tgt_ready = (w == 3) ? SEL_RAM : 4'b0000;
      #1;
      n_tests++;
      if ({stall, rsp_valid} !== 2'b10) begin
        $display("FAIL cam_wait: got s/v=%b want 10 (wait %0d)", {stall, rsp_valid}, w); n_fail++;
      end
      tick();
    end
    tgt_ready = SEL_CAM;
    tick();
    tgt_ready = '0;
    req_valid = 1'b0;
    #1;
    n_tests++;
    if ({rsp_valid, bus_error} !== 2'b10 || rdata !== 32'hCAFE_F00D) begin
      $display("FAIL cam_resp: got v/e=%b rdata=%h want 10 cafef00d",
               {rsp_valid, bus_error}, rdata); n_fail++;
    end
    tick();
  endtask

  task automatic test_illegal();
    logic [3:0] bad [2];
    bad[0] = 4'b0110;
    bad[1] = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      req_valid  = 1'b1;
      mem_select = bad[k];
      #1;
      n_tests++;
      if (stall !== 1'b1) begin
        $display("FAIL illegal_stall: got %b want 1 (sel %b)", stall, bad[k]); n_fail++;
      end
      tick();
      req_valid = 1'b0;
      #1;
      n_tests++;
      if ({rsp_valid, bus_error, stall} !== 3'b110 || rdata !== 32'h0) begin
        $display("FAIL illegal_resp: got v/e/s=%b rdata=%h want 110 00000000 (sel %b)",
                 {rsp_valid, bus_error, stall}, rdata, bad[k]); n_fail++;
      end
      tick();
      n_tests++;
      if ({rsp_valid, bus_error} !== 2'b00) begin
        $display("FAIL illegal_after: got v/e=%b want 00", {rsp_valid, bus_error}); n_fail++;
      end
    end
  endtask

  task automatic test_timeout();
    int waits;
    // Ready arrives in the final allowed WAIT cycle: still a good response.
    req_valid  = 1'b1;
    mem_select = SEL_IO;
    tgt_rdata[TGT_IO*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    tick();
    for (int w = 1; w <= 16; w++) begin
      if (w == 16) tgt_ready = SEL_IO;
      #1;
      n_tests++;
      if ({stall, rsp_valid} !== 2'b10) begin
        $display("FAIL late_ready_wait: got s/v=%b want 10 (wait %0d)", {stall, rsp_valid}, w);
        n_fail++;
      end
      tick();
    end
    tgt_ready = '0;
    req_valid = 1'b0;
    #1;
    n_tests++;
    if ({rsp_valid, bus_error} !== 2'b10 || rdata !== 32'hDEAD_BEEF) begin
      $display("FAIL late_ready_resp: got v/e=%b rdata=%h want 10 deadbeef",
               {rsp_valid, bus_error}, rdata); n_fail++;
    end
    tick();
    // No ready at all: forced error after exactly 16 WAIT cycles.
    req_valid = 1'b1;
    tick();
    waits = 0;
    while (rsp_valid !== 1'b1 && waits < 40) begin
      waits++;
      tick();
    end
    req_valid = 1'b0;
    #1;
    n_tests++;
    if (waits !== 16) begin
      $display("FAIL timeout_cycles: got %0d want 16", waits); n_fail++;
    end
    n_tests++;
    if ({rsp_valid, bus_error} !== 2'b11 || rdata !== 32'h0) begin
      $display("FAIL timeout_resp: got v/e=%b rdata=%h want 11 00000000",
               {rsp_valid, bus_error}, rdata); n_fail++;
    end
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_ram_load();
    test_store();
    test_reset_mid_wait();
    test_cam_latency();
    test_illegal();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
